// File: rtl/adc_ddr_capture_if.sv
// Valid/ready stream carrying packed ADC sample words toward the host FIFO.
interface adc_ddr_capture_if #(
  parameter int unsigned W = 48
) ();
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/adc_ddr_capture.sv
// Two-channel DDR ADC capture: input register, training-pattern lock FSM, pair packing, stream out.
// Optional ADC_RAMP_EN adds a ramp_mode input that substitutes an internal ramp for the ADC data.
module adc_ddr_capture #(
  parameter int unsigned     DW         = 6,
  parameter int unsigned     PACK       = 4,
  parameter logic [DW-1:0]   TRAIN_RISE = 6'h2A,
  parameter logic [DW-1:0]   TRAIN_FALL = 6'h15,
  parameter int unsigned     LOCK_CNT   = 64,
  parameter int unsigned     UNLOCK_ERR = 4,
  parameter bit              TRAIN_REQ  = 1'b1
) (
  input  logic                dco,
  input  logic                rst_n,
  input  logic [DW-1:0]       q_rise,
  input  logic [DW-1:0]       q_fall,
  input  logic                train_en,
  input  logic                fmt_twos,
`ifdef ADC_RAMP_EN
  input  logic                ramp_mode,
`endif
  adc_ddr_capture_if.master   stream,
  output logic                locked,
  output logic                overflow,
  output logic [15:0]         drop_cnt
);

  localparam int unsigned W  = 2 * DW * PACK;
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned EW = $clog2(UNLOCK_ERR + 1);
  localparam int unsigned IW = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic [MW-1:0] LockLast = MW'(LOCK_CNT - 1);
  localparam logic [EW-1:0] ErrLast  = EW'(UNLOCK_ERR - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(PACK - 1);

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  state_e          state_q;
  logic [DW-1:0]   r1, r2;
  logic [MW-1:0]   match_cnt;
  logic [EW-1:0]   err_cnt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    pack_buf;

  logic            match, capture, word_done, bypass;
  logic [2*DW-1:0] pair;
  logic [W-1:0]    word;

`ifdef ADC_RAMP_EN
  logic [DW-1:0]   ramp;
  logic            ramp_r;
  // ramp_r tracks whether r1/r2 currently hold ramp data, so the bypass lines up with them.
  assign bypass = ramp_r;
`else
  assign bypass = 1'b0;
`endif

  assign locked = (state_q == StLocked) || bypass;

  always_comb begin
    match     = (r1 == TRAIN_RISE) && (r2 == TRAIN_FALL);
    capture   = bypass || ((state_q == StLocked) && !train_en);
    pair      = {r2[DW-1] ^ fmt_twos, r2[DW-2:0], r1[DW-1] ^ fmt_twos, r1[DW-2:0]};
    word      = pack_buf;
    for (int i = 0; i < PACK; i++) begin
      if (IW'(i) == idx) word[i*2*DW +: 2*DW] = pair;
    end
    word_done = capture && (idx == IdxLast);
  end

  always_ff @(posedge dco or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= TRAIN_REQ ? StSearch : StLocked;
      r1               <= '0;
      r2               <= '0;
      match_cnt        <= '0;
      err_cnt          <= '0;
      idx              <= '0;
      pack_buf         <= '0;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
      overflow         <= 1'b0;
      drop_cnt         <= '0;
`ifdef ADC_RAMP_EN
      ramp             <= '0;
      ramp_r           <= 1'b0;
`endif
    end else begin
`ifdef ADC_RAMP_EN
      ramp_r <= ramp_mode;
      if (ramp_mode) begin
        r1   <= ramp;
        r2   <= ramp + DW'(1);
        ramp <= ramp + DW'(2);
      end else begin
        r1 <= q_rise;
        r2 <= q_fall;
      end
`else
      r1 <= q_rise;
      r2 <= q_fall;
`endif

      // Outside capture the index is held at 0, which discards any partial word.
      if (capture) begin
        pack_buf <= word;
        idx      <= word_done ? '0 : idx + 1'b1;
      end else begin
        idx <= '0;
      end

      if (!bypass) begin
        unique case (state_q)
          StSearch: begin
            if (!match) begin
              match_cnt <= '0;
            end else if (match_cnt == LockLast) begin
              state_q   <= StLocked;
              match_cnt <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          StLocked: begin
            if (!train_en || match) begin
              err_cnt <= '0;
            end else if (err_cnt == ErrLast) begin
              state_q   <= StSearch;
              err_cnt   <= '0;
              match_cnt <= '0;
            end else begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
        endcase
      end

      if (word_done && (!stream.out_valid || stream.out_ready)) begin
        stream.out_data  <= word;
        stream.out_valid <= 1'b1;
      end else if (word_done) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (stream.out_valid && stream.out_ready) begin
        stream.out_valid <= 1'b0;
      end
    end
  end

endmodule
